// File: rtl/lcd_bus_sched.sv
// HD44780-style LCD bus sequencer: passes init-sequencer commands through with an E strobe,
// then round-robin arbitrates two byte-write requesters and times each setup/E/hold/exec cycle.
module lcd_bus_sched #(
    parameter int T_SETUP = 2,
    parameter int T_EHIGH = 25,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2500,
    parameter int T_CLEAR = 82000,
    parameter int CW      = 17
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Init_Done,
    input  logic [7:0] Init_Dato,
    input  logic       Req0,
    input  logic       Rs0,
    input  logic [7:0] Data0,
    output logic       Ack0,
    input  logic       Req1,
    input  logic       Rs1,
    input  logic [7:0] Data1,
    output logic       Ack1,
    output logic       Busy,
    output logic [7:0] LCD_Data,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E
);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_SETUP,
        S_E_HIGH,
        S_HOLD,
        S_EXEC
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_timer;
    logic [7:0]      r_prev_init;
    logic            r_last;
    logic            r_init_path;

    logic            w_init_new;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_is_clear;
    logic [CW-1:0]   w_phase_last;
    logic            w_timer_done;

    assign LCD_RW = 1'b0;

    always_comb begin
        w_init_new = (Init_Dato != r_prev_init) && (Init_Dato != 8'h00);
        // On a tie the requester that was not served last wins.
        w_grant0   = Req0 && (!Req1 || r_last);
        w_grant1   = Req1 && (!Req0 || !r_last);
        w_is_clear = !LCD_RS && ((LCD_Data == 8'h01) || (LCD_Data == 8'h02) || (LCD_Data == 8'h03));
        case (r_state)
            S_SETUP:  w_phase_last = CW'(T_SETUP - 1);
            S_E_HIGH: w_phase_last = CW'(T_EHIGH - 1);
            S_HOLD:   w_phase_last = CW'(T_HOLD - 1);
            S_EXEC:   w_phase_last = w_is_clear ? CW'(T_CLEAR - 1) : CW'(T_EXEC - 1);
            default:  w_phase_last = '0;
        endcase
        w_timer_done = (r_timer == w_phase_last);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= S_WAIT_INIT;
            r_timer     <= '0;
            r_prev_init <= 8'h00;
            r_last      <= 1'b1;
            r_init_path <= 1'b0;
            LCD_Data    <= 8'h00;
            LCD_RS      <= 1'b0;
            LCD_E       <= 1'b0;
            Ack0        <= 1'b0;
            Ack1        <= 1'b0;
            Busy        <= 1'b1;
        end else begin
            Ack0    <= 1'b0;
            Ack1    <= 1'b0;
            r_timer <= r_timer + 1'b1;
            if (r_state == S_WAIT_INIT) begin
                LCD_E    <= 1'b0;
                LCD_RS   <= 1'b0;
                LCD_Data <= Init_Dato;
                if (w_init_new) begin
                    r_prev_init <= Init_Dato;
                    r_init_path <= 1'b1;
                    r_state     <= S_SETUP;
                    r_timer     <= '0;
                end else if (Init_Done) begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    Busy    <= 1'b0;
                end
            end else if (!r_init_path && !Init_Done) begin
                // Init sequencer restarted: abandon any write without acking.
                r_state  <= S_WAIT_INIT;
                r_timer  <= '0;
                LCD_E    <= 1'b0;
                LCD_RS   <= 1'b0;
                LCD_Data <= Init_Dato;
                Busy     <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_grant0) begin
                            LCD_Data <= Data0;
                            LCD_RS   <= Rs0;
                            r_last   <= 1'b0;
                            Ack0     <= 1'b1;
                            r_state  <= S_SETUP;
                            r_timer  <= '0;
                            Busy     <= 1'b1;
                        end else if (w_grant1) begin
                            LCD_Data <= Data1;
                            LCD_RS   <= Rs1;
                            r_last   <= 1'b1;
                            Ack1     <= 1'b1;
                            r_state  <= S_SETUP;
                            r_timer  <= '0;
                            Busy     <= 1'b1;
                        end
                    end
                    S_SETUP: begin
                        if (w_timer_done) begin
                            r_state <= S_E_HIGH;
                            r_timer <= '0;
                            LCD_E   <= 1'b1;
                        end
                    end
                    S_E_HIGH: begin
                        if (w_timer_done) begin
                            r_state <= S_HOLD;
                            r_timer <= '0;
                            LCD_E   <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (w_timer_done) begin
                            r_timer <= '0;
                            // Init commands get no exec wait; the sequencer spaces them itself.
                            if (r_init_path) begin
                                r_init_path <= 1'b0;
                                r_state     <= S_WAIT_INIT;
                            end else begin
                                r_state <= S_EXEC;
                            end
                        end
                    end
                    S_EXEC: begin
                        if (w_timer_done) begin
                            r_state <= S_IDLE;
                            r_timer <= '0;
                            Busy    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_WAIT_INIT;
                        r_timer <= '0;
                        LCD_E   <= 1'b0;
                        Busy    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Directed bench for lcd_bus_sched: init pass-through, arbitration, strobe timing and aborts.
module tb_lcd_bus_sched;

    localparam int T_SETUP = 2;
    localparam int T_EHIGH = 4;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 10;
    localparam int T_CLEAR = 40;
    localparam int WR_NORM = T_SETUP + T_EHIGH + T_HOLD + T_EXEC;
    localparam int WR_CLR  = T_SETUP + T_EHIGH + T_HOLD + T_CLEAR;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       Init_Done = 1'b0;
    logic [7:0] Init_Dato = 8'h00;
    logic       Req0 = 1'b0, Rs0 = 1'b0, Req1 = 1'b0, Rs1 = 1'b0;
    logic [7:0] Data0 = 8'h00, Data1 = 8'h00;
    logic       Ack0, Ack1, Busy, LCD_RS, LCD_RW, LCD_E;
    logic [7:0] LCD_Data;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_bus_sched #(
        .T_SETUP(T_SETUP), .T_EHIGH(T_EHIGH), .T_HOLD(T_HOLD),
        .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR), .CW(17)
    ) dut (
        .CLK(CLK), .Reset(Reset), .Init_Done(Init_Done), .Init_Dato(Init_Dato),
        .Req0(Req0), .Rs0(Rs0), .Data0(Data0), .Ack0(Ack0),
        .Req1(Req1), .Rs1(Rs1), .Data1(Data1), .Ack1(Ack1),
        .Busy(Busy), .LCD_Data(LCD_Data), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E)
    );

    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Steps n cycles, summarising E activity and any acks seen.
    task automatic watch(input int n, output int e_cyc, output int rises,
                         output logic [7:0] dat, output int rs_hi, output int acks);
        logic prev_e;
        prev_e = LCD_E;
        e_cyc = 0; rises = 0; dat = 8'h00; rs_hi = 0; acks = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (LCD_E) begin
                e_cyc++;
                dat = LCD_Data;
                if (LCD_RS) rs_hi++;
                if (!prev_e) rises++;
            end
            if (Ack0 || Ack1) acks++;
            prev_e = LCD_E;
        end
    endtask

    // Called right after a grant edge; k counts edges after the grant.
    task automatic measure(input logic [7:0] exp_data, input logic exp_rs,
                           output int e_first, output int e_last, output int idle_at,
                           output int stable, output int acks);
        e_first = -1; e_last = -1; idle_at = -1; stable = 1; acks = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (LCD_E) begin
                if (e_first < 0) e_first = k;
                e_last = k;
            end
            if (Ack0 || Ack1) acks++;
            if (LCD_Data !== exp_data || LCD_RS !== exp_rs) stable = 0;
            if (!Busy) begin
                idle_at = k;
                break;
            end
        end
    endtask

    initial begin
        int ec, ri, rh, ak, ef, el, ia, st;
        int acks_total, ack_k[3], ack_id[3], n_ack;
        logic [7:0] dt;

        // Reset state
        step(); step();
        chk_eq("rst_E", LCD_E, 1'b0);
        chk_eq("rst_Busy", Busy, 1'b1);
        chk_eq("rst_Ack", {Ack0, Ack1}, 2'b00);
        chk_eq("rst_Data", LCD_Data, 8'h00);
        chk_eq("rst_RS", LCD_RS, 1'b0);
        chk_eq("rst_RW", LCD_RW, 1'b0);
        Reset = 1'b0;
        step();

        // Init pass-through with requests held to prove they are ignored
        Req0 = 1'b1; Req1 = 1'b1; Data0 = 8'hAA; Data1 = 8'hBB; Rs0 = 1'b1; Rs1 = 1'b1;
        acks_total = 0;
        Init_Dato = 8'h38;
        watch(12, ec, ri, dt, rh, ak); acks_total += ak;
        chk_eq("init38_rises", ri, 1); chk_eq("init38_ecyc", ec, T_EHIGH);
        chk_eq("init38_data", dt, 8'h38); chk_eq("init38_rs", rh, 0);
        watch(12, ec, ri, dt, rh, ak); acks_total += ak;
        chk_eq("init38_repeat_rises", ri, 0);
        Init_Dato = 8'h06;
        watch(12, ec, ri, dt, rh, ak); acks_total += ak;
        chk_eq("init06_rises", ri, 1); chk_eq("init06_ecyc", ec, T_EHIGH);
        chk_eq("init06_data", dt, 8'h06); chk_eq("init06_rs", rh, 0);
        Init_Dato = 8'h0C;
        watch(12, ec, ri, dt, rh, ak); acks_total += ak;
        chk_eq("init0C_rises", ri, 1); chk_eq("init0C_data", dt, 8'h0C);
        chk_eq("init_acks", acks_total, 0);
        chk_eq("init_busy", Busy, 1'b1);
        chk_eq("init_follow", LCD_Data, 8'h0C);

        // Init done -> IDLE one edge later
        Req0 = 1'b0; Req1 = 1'b0;
        Init_Done = 1'b1;
        step();
        chk_eq("done_busy", Busy, 1'b0);

        // Character write from requester 1
        Req1 = 1'b1; Rs1 = 1'b1; Data1 = 8'h41;
        step();
        chk_eq("chr_ack", {Ack0, Ack1}, 2'b01);
        chk_eq("chr_data", LCD_Data, 8'h41);
        Req1 = 1'b0; Data1 = 8'hFF;
        measure(8'h41, 1'b1, ef, el, ia, st, ak);
        chk_eq("chr_e_first", ef, T_SETUP);
        chk_eq("chr_e_last", el, T_SETUP + T_EHIGH - 1);
        chk_eq("chr_idle", ia, WR_NORM);
        chk_eq("chr_stable", st, 1);
        chk_eq("chr_ack_once", ak, 0);

        // Round-robin with both requesters held (last grant was 1, so 0 wins first)
        Req0 = 1'b1; Rs0 = 1'b1; Data0 = 8'h30;
        Req1 = 1'b1; Rs1 = 1'b1; Data1 = 8'h31;
        n_ack = 0;
        for (int k = 1; k <= 120 && n_ack < 3; k++) begin
            step();
            if (Ack0 || Ack1) begin
                ack_k[n_ack]  = k;
                ack_id[n_ack] = Ack1 ? 1 : 0;
                n_ack++;
            end
        end
        Req0 = 1'b0; Req1 = 1'b0;
        chk_eq("rr_count", n_ack, 3);
        if (n_ack == 3) begin
            chk_eq("rr_order", {ack_id[0][1:0], ack_id[1][1:0], ack_id[2][1:0]}, 6'b00_01_00);
            chk_eq("rr_gap1", ack_k[1] - ack_k[0], WR_NORM + 1);
            chk_eq("rr_gap2", ack_k[2] - ack_k[1], WR_NORM + 1);
        end
        measure(8'h30, 1'b1, ef, el, ia, st, ak);
        chk_eq("rr_idle", ia, WR_NORM);

        // Clear command gets the long wait
        Req0 = 1'b1; Rs0 = 1'b0; Data0 = 8'h01;
        step();
        chk_eq("clr_ack", {Ack0, Ack1}, 2'b10);
        Req0 = 1'b0;
        measure(8'h01, 1'b0, ef, el, ia, st, ak);
        chk_eq("clr_idle", ia, WR_CLR);
        chk_eq("clr_stable", st, 1);

        // Reset pulsed during E_HIGH
        Init_Dato = 8'h00;
        Req0 = 1'b1; Rs0 = 1'b1; Data0 = 8'h55;
        step();
        chk_eq("rst_wr_ack", Ack0, 1'b1);
        Req0 = 1'b0;
        step(); step();
        chk_eq("rst_wr_ehigh", LCD_E, 1'b1);
        Reset = 1'b1; Init_Done = 1'b0;
        step();
        Reset = 1'b0;
        chk_eq("rstmid_E", LCD_E, 1'b0);
        chk_eq("rstmid_busy", Busy, 1'b1);
        chk_eq("rstmid_data", LCD_Data, 8'h00);
        Req0 = 1'b1;
        watch(10, ec, ri, dt, rh, ak);
        chk_eq("rstmid_noack", ak, 0);
        chk_eq("rstmid_noe", ri, 0);
        Init_Done = 1'b1;
        step();
        chk_eq("rstmid_idle", {Busy, Ack0}, 2'b00);
        step();
        chk_eq("rstmid_ack", Ack0, 1'b1);
        Req0 = 1'b0;
        measure(8'h55, 1'b1, ef, el, ia, st, ak);
        chk_eq("rstmid_wr_idle", ia, WR_NORM);

        // Init_Done drops during EXEC
        Req0 = 1'b1; Rs0 = 1'b1; Data0 = 8'h07;
        step();
        chk_eq("drop_ack", Ack0, 1'b1);
        Req0 = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk_eq("drop_in_exec", {Busy, LCD_E, LCD_Data}, {2'b10, 8'h07});
        Req0 = 1'b1; Init_Done = 1'b0;
        step();
        chk_eq("drop_wait_init", {Busy, LCD_E, LCD_Data}, {2'b10, 8'h00});
        watch(25, ec, ri, dt, rh, ak);
        chk_eq("drop_noack", ak, 0);
        chk_eq("drop_busy", Busy, 1'b1);
        Init_Done = 1'b1;
        step();
        chk_eq("drop_idle", {Busy, Ack0}, 2'b00);
        step();
        chk_eq("drop_reack", Ack0, 1'b1);
        Req0 = 1'b0;
        measure(8'h07, 1'b1, ef, el, ia, st, ak);
        chk_eq("drop_wr_idle", ia, WR_NORM);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
